// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter one frame at a time.
// Ports: clk, rst_n (async, active-low), wr_en/wr_data (enqueue strobe),
//   full/empty/count (occupancy), overflow (dropped-write pulse),
//   transmit/tx_byte (UART start pulse + byte), is_transmitting (UART busy).
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    input  logic              is_transmitting
);

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              pop;

    // Flags come from the count register only, so nothing on the
    // input side reaches an output combinationally.
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // A write into a full FIFO is dropped even if a pop frees a slot
    // on the same edge.
    assign wr_ok = wr_en && !full;
    assign pop   = (state == IDLE) && !empty && !is_transmitting;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({wr_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // The UART raises its busy flag some time after the start pulse, so
    // wait to see it high before waiting for it to drop again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            transmit <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        tx_byte  <= mem[rd_ptr];
                        transmit <= 1'b1;
                        state    <= WAIT_BUSY;
                    end else begin
                        transmit <= 1'b0;
                    end
                end
                WAIT_BUSY: begin
                    transmit <= 1'b0;
                    if (is_transmitting) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    transmit <= 1'b0;
                    if (!is_transmitting) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    transmit <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a simple UART
// busy-flag model and a transmit-pulse monitor.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;

    logic       hold = 1'b0;
    logic       model_busy = 1'b0;
    int         busy_len = 20;
    int         busy_cnt = 0;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_cyc = -1;
    int         min_gap = 1000000;
    int         ovf_cnt = 0;
    int         max_count = 0;
    logic [7:0] q[$];

    assign is_transmitting = hold | model_busy;

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .transmit(transmit),
        .tx_byte(tx_byte),
        .is_transmitting(is_transmitting)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // UART model: goes busy on a start pulse for busy_len cycles.
    always @(negedge clk) begin
        if (transmit && rst_n) begin
            model_busy = 1'b1;
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) model_busy = 1'b0;
        end
    end

    // Monitor: transmitted bytes, pulse spacing, overflow pulses, occupancy.
    always @(negedge clk) begin
        if (rst_n) begin
            if (transmit) begin
                q.push_back(tx_byte);
                if (last_cyc >= 0 && (cyc - last_cyc) < min_gap)
                    min_gap = cyc - last_cyc;
                last_cyc = cyc;
            end
            if (overflow) ovf_cnt++;
            if (int'(count) > max_count) max_count = int'(count);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        @(negedge clk);
        #2;
        q.delete();
        last_cyc = -1;
        min_gap = 1000000;
        ovf_cnt = 0;
        max_count = 0;
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic wait_pulses(input string tag, input int n,
                               input int budget);
        int k;
        k = 0;
        while (q.size() < n && k < budget) begin
            @(negedge clk);
            wr_en = 1'b0;
            k++;
        end
        check(tag, q.size(), n);
    endtask

    initial begin
        // Reset state
        idle(2);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_transmit", transmit, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();

        // Single byte
        wr(8'h41);
        idle(1);
        check("single_empty", empty, 0);
        check("single_count1", count, 1);
        check("single_tx_early", transmit, 0);
        idle(1);
        check("single_transmit", transmit, 1);
        check("single_tx_byte", tx_byte, 8'h41);
        check("single_count0", count, 0);
        idle(1);
        check("single_pulse_end", transmit, 0);
        idle(30);
        check("single_pulses", q.size(), 1);

        // Burst of 16 with a 20-cycle busy window
        clr();
        for (int i = 0; i < 16; i++) wr(8'(i));
        idle(1);
        wait_pulses("burst_pulses", 16, 600);
        for (int i = 0; i < 16; i++)
            check($sformatf("burst_byte%0d", i), q[i], 8'(i));
        check("burst_min_gap", min_gap, 22);
        check("burst_no_ovf", ovf_cnt, 0);
        idle(30);

        // Overflow: 17 writes while the UART is held busy
        clr();
        @(negedge clk);
        hold = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 16) begin
                check("ovf_full", full, 1);
                check("ovf_count16", count, 16);
            end
            wr_en = 1'b1;
            wr_data = 8'(8'h10 + i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("ovf_pulse", overflow, 1);
        check("ovf_count_kept", count, 16);
        @(negedge clk);
        check("ovf_pulse_end", overflow, 0);
        idle(3);
        check("ovf_pulse_count", ovf_cnt, 1);
        check("ovf_no_tx_held", q.size(), 0);
        hold = 1'b0;
        wait_pulses("ovf_pulses", 16, 600);
        for (int i = 0; i < 16; i++)
            check($sformatf("ovf_byte%0d", i), q[i], 8'(8'h10 + i));
        idle(40);
        check("ovf_no_extra", q.size(), 16);
        check("ovf_drained", empty, 1);

        // Wrap-around: 40 bytes with gaps, short busy window
        busy_len = 2;
        clr();
        for (int i = 0; i < 40; i++) begin
            wr(8'(8'h40 + i));
            idle(2 + (i % 4));
        end
        wait_pulses("wrap_pulses", 40, 400);
        for (int i = 0; i < 40; i++)
            check($sformatf("wrap_byte%0d", i), q[i], 8'(8'h40 + i));
        check("wrap_max_count", 32'(max_count <= 16), 1);
        check("wrap_no_ovf", ovf_cnt, 0);
        idle(10);

        // Simultaneous write and pop at count 3
        clr();
        @(negedge clk);
        hold = 1'b1;
        wr(8'hA0);
        wr(8'hA1);
        wr(8'hA2);
        idle(1);
        check("sim_count3", count, 3);
        hold = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'hA3;
        @(negedge clk);
        wr_en = 1'b0;
        check("sim_count_kept", count, 3);
        check("sim_transmit", transmit, 1);
        check("sim_tx_byte", tx_byte, 8'hA0);
        wait_pulses("sim_pulses", 4, 100);
        for (int i = 0; i < 4; i++)
            check($sformatf("sim_byte%0d", i), q[i], 8'(8'hA0 + i));
        idle(10);

        // Reset mid-frame with 5 bytes queued
        busy_len = 20;
        clr();
        for (int i = 0; i < 6; i++) wr(8'(8'hB0 + i));
        idle(3);
        check("mid_count5", count, 5);
        check("mid_one_pulse", q.size(), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_full", full, 0);
        check("mid_rst_transmit", transmit, 0);
        check("mid_rst_tx_byte", tx_byte, 8'h00);
        check("mid_rst_overflow", overflow, 0);
        idle(2);
        rst_n = 1'b1;
        idle(60);
        check("mid_no_tx_after", q.size(), 1);
        wr(8'hC5);
        wait_pulses("mid_new_pulse", 2, 60);
        check("mid_new_byte", q[1], 8'hC5);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO and transmit sequencer between a byte producer (the UART receive strobe, or any fabric logic) and the `uart` core's transmit port. It accepts bytes on a single-cycle write strobe, stores up to `DEPTH` of them, and feeds them one at a time to the UART. It issues a one-cycle `transmit` pulse with a stable `tx_byte`, and sequences on `is_transmitting` so that back-to-back received bytes are never lost while a frame is still on the wire.

## Interface
- `DEPTH`, 16: FIFO capacity in bytes; must be a power of two, 2..256.
- `ADDR_W`, 4: pointer width; must equal log2(`DEPTH`).

- `clk`  in  1: system clock (12 MHz on the board).
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `wr_en`  in  1: write strobe; one byte per cycle while high.
- `wr_data`  in  8: byte to enqueue.
- `full`  out  1: FIFO holds `DEPTH` bytes.
- `empty`  out  1: FIFO holds 0 bytes.
- `count`  out  ADDR_W+1: current occupancy, 0..`DEPTH`.
- `overflow`  out  1: one-cycle pulse when a write is dropped because the FIFO is full.
- `transmit`  out  1: one-cycle start pulse to the UART.
- `tx_byte`  out  8: byte presented to the UART; held stable from the `transmit` pulse until the next pop.
- `is_transmitting`  in  1: UART busy flag; high while a frame is being sent.

## Operation
- Storage is a `DEPTH`×8 register array with `ADDR_W`-bit read and write pointers, both wrapping modulo `DEPTH`.
- `count` is an explicit register, not derived from pointer difference.
  - `full` = (`count` == `DEPTH`).
  - `empty` = (`count` == 0).
- Write:
  - Accepted when `wr_en` && !`full`, as sampled before the clock edge. The edge stores `wr_data`, increments the write pointer, and increments `count`.
  - When `wr_en` && `full`, the byte is dropped, the FIFO is unchanged, and `overflow` is 1 for the next cycle.
  - A write on a full FIFO is dropped even if a pop occurs on the same edge.
- Pop: performed only by the FSM. It increments the read pointer and decrements `count`.
- Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- FSM states:
  - IDLE: if !`empty` && !`is_transmitting`, pop the head into `tx_byte`, set `transmit`=1, and go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: `transmit`=0. If `is_transmitting`=1, go to WAIT_DONE. Otherwise stay.
  - WAIT_DONE: if `is_transmitting`=0, go to IDLE. Otherwise stay.
- `transmit` is registered and is high for exactly one cycle per popped byte.
- Reset (async, `rst_n`=0) sets:
  - both pointers, `count`=0, `empty`=1, `full`=0;
  - `overflow`=0, `transmit`=0, `tx_byte`=8'h00;
  - FSM=IDLE.
  - Array contents need not be cleared.
- Reset mid-frame: the FSM returns to IDLE and queued bytes are discarded. The UART's own frame is not aborted by this block.

## Timing
- A write sampled at edge N updates `count`/`empty` after edge N.
- With the FSM in IDLE and `is_transmitting`=0, edge N+1 pops:
  - `transmit` is high during the cycle after N+1, with `tx_byte` valid in the same cycle.
  - Write-to-`transmit` latency is 1 cycle after the storing edge.
- The next pop cannot occur until `is_transmitting` has been seen high and then low, plus one cycle in IDLE.
- `overflow` asserts during the cycle after the rejected-write edge, for one cycle per rejected write.
- All outputs are registered or decoded from registers only; there is no combinational path from `wr_en`/`is_transmitting` to any output.

## Test plan
- Single byte: write 8'h41 with the UART idle.
  - `empty` falls after 1 edge.
  - `transmit` pulses once, 1 cycle later, with `tx_byte`=8'h41.
  - `count` returns to 0.
- Burst: write 8'h00..8'h0F on consecutive cycles while a bench UART model holds `is_transmitting` for 20 cycles per frame.
  - 16 `transmit` pulses, bytes in order 00..0F.
  - No two pulses closer than the busy window.
  - No `overflow`.
- Overflow: hold `is_transmitting`=1, then write 17 bytes (`DEPTH`=16) 8'h10..8'h20.
  - `full`=1 and `count`=16 after the 16th write.
  - 17th byte (8'h20) dropped with a single `overflow` pulse.
  - After release, output is 10..1F.
- Wrap-around: 40 bytes streamed with gaps so the pointers wrap twice.
  - Output sequence equals input sequence.
  - `count` never exceeds 16.
- Simultaneous write and pop with `count`=3: `count` stays 3 and both bytes keep their order.
- Reset mid-operation: assert `rst_n`=0 asynchronously between edges with 5 bytes queued and the FSM in WAIT_DONE.
  - Outputs reach their reset values immediately.
  - After release, no `transmit` occurs until a new write.
